// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble sequencer: arithmetic-unit function codes
// and the sequencer state encoding, so the unit wrapper and benches agree.
package alu_nibble_sequencer_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;  // A + B + Cin
  localparam logic [1:0] OP_SUB     = 2'b01;  // A + ~B + Cin
  localparam logic [1:0] OP_INC_CIN = 2'b10;  // A + Cin
  localparam logic [1:0] OP_DEC     = 2'b11;  // A + 0xF + Cin

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// WIDTH-bit arithmetic sequenced over an external 4-bit unit, one nibble per
// cycle, LSB first, with carry chained through a local register.
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic [3:0]       au_A,
  output logic [3:0]       au_B,
  output logic [1:0]       au_S,
  output logic             au_C_in,
  input  logic [3:0]       au_D,
  input  logic             au_C_out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       sel_q;
  logic             carry_q;
  logic             zero_q;
  logic [IDX_W-1:0] idx_q;
  logic             accept;
  logic             last_nibble;

  assign accept      = (state_q == ST_IDLE) && in_valid;
  assign last_nibble = (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first; without it a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)    state_d = ST_RUN;
      ST_RUN:  if (last_nibble) state_d = ST_DONE;
      ST_DONE: if (out_ready)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    au_A      = 4'h0;
    au_B      = 4'h0;
    au_S      = 2'b00;
    au_C_in   = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN: begin
        au_A    = a_q[4*idx_q +: 4];
        au_B    = b_q[4*idx_q +: 4];
        au_S    = sel_q;
        au_C_in = carry_q;
      end
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Merge the unit's nibble into the result so zero sees the final value.
  always_comb begin
    result_d = result_q;
    result_d[4*idx_q +: 4] = au_D;
  end

  // NOTE: these are plain registers, not a memory array, so all of them
  // take the reset value; nothing here relies on power-up contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 2'b00;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= op_a;
      b_q      <= op_b;
      sel_q    <= op_sel;
      carry_q  <= carry_in;
      idx_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (state_q == ST_RUN) begin
      result_q <= result_d;
      carry_q  <= au_C_out;
      idx_q    <= idx_q + IDX_W'(1);
      if (last_nibble) zero_q <= (result_d == '0);
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboarded bench: a behavioural 4-bit unit on the au_* ports and a
// full-width reference model producing expected results at acceptance.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_sel;
  logic             carry_in;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out, zero;
  logic [3:0]       au_A, au_B, au_D;
  logic [1:0]       au_S;
  logic             au_C_in, au_C_out;
  logic [4:0]       au_sum;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] au_a_seen[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero),
    .au_A(au_A), .au_B(au_B), .au_S(au_S), .au_C_in(au_C_in),
    .au_D(au_D), .au_C_out(au_C_out)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit arithmetic unit.
  always_comb begin
    au_sum = 5'h0;
    case (au_S)
      OP_ADD:     au_sum = {1'b0, au_A} + {1'b0, au_B} + 5'(au_C_in);
      OP_SUB:     au_sum = {1'b0, au_A} + {1'b0, ~au_B} + 5'(au_C_in);
      OP_INC_CIN: au_sum = {1'b0, au_A} + 5'(au_C_in);
      default:    au_sum = {1'b0, au_A} + 5'h0F + 5'(au_C_in);
    endcase
    au_D     = au_sum[3:0];
    au_C_out = au_sum[4];
  end

  function automatic exp_t ref_model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                     logic [1:0] sel, logic cin);
    exp_t         e;
    logic [WIDTH:0] s;
    case (sel)
      OP_ADD:     s = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
      OP_SUB:     s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
      OP_INC_CIN: s = {1'b0, a} + (WIDTH+1)'(cin);
      default:    s = {1'b0, a} + {1'b0, {WIDTH{1'b1}}} + (WIDTH+1)'(cin);
    endcase
    e.res = s[WIDTH-1:0];
    e.c   = s[WIDTH];
    e.z   = (s[WIDTH-1:0] == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"},  32'(in_ready), 1);
    check({tag, "_result"},    32'(result), 0);
    check({tag, "_carry_out"}, 32'(carry_out), 0);
    check({tag, "_zero"},      32'(zero), 0);
    check({tag, "_au"},        {21'h0, au_A, au_B, au_S, au_C_in}, 0);
  endtask

  // Drive one operation, score it, optionally backpressure for `hold` cycles.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [1:0] sel,
                        input logic cin, input int hold);
    int   cyc;
    logic done;
    exp_t e;
    au_a_seen.delete();
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 1);
    op_a = a; op_b = b; op_sel = sel; carry_in = cin; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(ref_model(a, b, sel, cin));
    #1;
    in_valid = 1'b0;
    op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
    op_sel = 2'($urandom); carry_in = ~cin;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else begin
        au_a_seen.push_back(au_A);
        cyc++;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'(cyc), 4);
      return;
    end
    check({tag, "_latency"}, 32'(cyc), 4);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_carry"},  32'(carry_out), 32'(e.c));
    check({tag, "_zero"},   32'(zero), 32'(e.z));
    check({tag, "_done_au"}, {21'h0, au_A, au_B, au_S, au_C_in}, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"},  32'(out_valid), 1);
      check({tag, "_hold_ready"},  32'(in_ready), 0);
      check({tag, "_hold_result"}, 32'(result), 32'(e.res));
      check({tag, "_hold_carry"},  32'(carry_out), 32'(e.c));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_release_valid"}, 32'(out_valid), 0);
    check({tag, "_release_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int vhigh;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_sel = 2'b00; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Add with au_A nibble sequence LSB first.
    run_op("add", 16'h1234, 16'h0FFF, OP_ADD, 1'b0, 0);
    check("add_au_count", 32'(au_a_seen.size()), 4);
    if (au_a_seen.size() == 4) begin
      check("add_au0", 32'(au_a_seen[0]), 4);
      check("add_au1", 32'(au_a_seen[1]), 3);
      check("add_au2", 32'(au_a_seen[2]), 2);
      check("add_au3", 32'(au_a_seen[3]), 1);
    end

    run_op("sub_pos",  16'h0007, 16'h0005, OP_SUB,     1'b1, 0);
    run_op("sub_neg",  16'h0005, 16'h0007, OP_SUB,     1'b1, 0);
    run_op("inc_wrap", 16'hFFFF, 16'h1234, OP_INC_CIN, 1'b1, 0);
    run_op("dec_zero", 16'h0000, 16'h0000, OP_DEC,     1'b0, 0);
    run_op("dec_1000", 16'h1000, 16'hABCD, OP_DEC,     1'b0, 0);

    // Backpressure with input toggling while DONE.
    run_op("bp", 16'h8421, 16'h1248, OP_ADD, 1'b1, 5);

    for (int i = 0; i < 4; i++)
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 2'(i), 1'($urandom), 0);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FFF; op_sel = OP_ADD; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(ref_model(16'h1234, 16'h0FFF, OP_ADD, 1'b0));
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle_outputs("abort");
    vhigh = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vhigh++;
    end
    check("abort_no_valid", 32'(vhigh), 0);

    run_op("after_abort", 16'h1234, 16'h0FFF, OP_ADD, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
